// File: rtl/modulo_mux8_1_scan_reader.sv
// Receiver for the 1-of-8 active-low select bus: sweeps input_sel, samples the addressed
// line once per dwell period, assembles 8-bit frames and flags contention on idle lines.
module modulo_mux8_1_scan_reader #(
    parameter int DWELL = 4,
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       hold,
    input  logic [7:0] Nin,
    input  logic       clr_err,
    output logic [2:0] input_sel,
    output logic       A_out,
    output logic [7:0] data_out,
    output logic       frame_valid,
    output logic       err
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shadow_q, shadow_d;
    logic [7:0]       data_q, data_d;
    logic             a_out_q, a_out_d;
    logic             frame_valid_q, frame_valid_d;
    logic             err_q, err_d;

    logic [2:0]       line;
    logic [7:0]       line_mask;
    logic [7:0]       sampled;
    logic             sample;
    logic             contention;

    // Code s addresses line 7-s; any other line pulled low means a second driver is active.
    assign line       = 3'd7 - sel_q;
    assign line_mask  = 8'b1 << line;
    assign sampled    = (shadow_q & ~line_mask) | (Nin & line_mask);
    assign sample     = (state_q == SCAN) && enable && (cnt_q == LAST_CNT);
    assign contention = |(~Nin & ~line_mask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sel_q         <= 3'd0;
            cnt_q         <= '0;
            shadow_q      <= 8'hFF;
            data_q        <= 8'hFF;
            a_out_q       <= 1'b1;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            data_q        <= data_d;
            a_out_q       <= a_out_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (enable)  state_d = SCAN;
            SCAN: if (!enable) state_d = IDLE;
        endcase
    end

    // Dropping enable discards the partial frame; it takes priority over a pending sample.
    always_comb begin
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        data_d        = data_q;
        a_out_d       = a_out_q;
        frame_valid_d = 1'b0;
        err_d         = err_q & ~clr_err;

        if ((state_q == IDLE) || !enable) begin
            sel_d    = 3'd0;
            cnt_d    = '0;
            shadow_d = 8'hFF;
        end else if (sample) begin
            cnt_d    = '0;
            a_out_d  = Nin[line];
            shadow_d = sampled;
            if (contention) begin
                err_d = 1'b1;
            end
            if (!hold) begin
                if (sel_q == 3'd7) begin
                    sel_d         = 3'd0;
                    data_d        = sampled;
                    frame_valid_d = 1'b1;
                    shadow_d      = 8'hFF;
                end else begin
                    sel_d = sel_q + 3'd1;
                end
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign input_sel   = sel_q;
    assign A_out       = a_out_q;
    assign data_out    = data_q;
    assign frame_valid = frame_valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_modulo_mux8_1_scan_reader.sv
// Bench for modulo_mux8_1_scan_reader: directed scenarios plus random traffic, every cycle
// compared against a channel/tick reference model of the select-bus receiver.
module tb_modulo_mux8_1_scan_reader;

    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       hold;
    logic [7:0] Nin;
    logic       clr_err;
    logic [2:0] input_sel;
    logic       A_out;
    logic [7:0] data_out;
    logic       frame_valid;
    logic       err;

    int         n_cmp = 0;
    int         n_fail = 0;
    bit         checking = 1'b0;

    logic [7:0] bus_byte = 8'hB2;
    bit         ovr = 1'b0;
    logic [7:0] ovr_val = 8'hFF;

    always #5 clk = ~clk;

    modulo_mux8_1_scan_reader #(.DWELL(DWELL), .CNT_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .hold        (hold),
        .Nin         (Nin),
        .clr_err     (clr_err),
        .input_sel   (input_sel),
        .A_out       (A_out),
        .data_out    (data_out),
        .frame_valid (frame_valid),
        .err         (err)
    );

    // Reference model: which channel is being dwelt on, how long, and the bits collected so far.
    bit         m_scan;
    int         m_tick, m_ch, m_line;
    logic [7:0] m_bits, m_data;
    logic       m_a, m_fv, m_err, m_cont;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_scan = 0; m_tick = 0; m_ch = 0; m_bits = 8'hFF; m_data = 8'hFF;
            m_a = 1'b1; m_fv = 1'b0; m_err = 1'b0;
        end else begin
            m_fv   = 1'b0;
            m_cont = 1'b0;
            if (!m_scan || !enable) begin
                m_ch = 0; m_tick = 0; m_bits = 8'hFF;
                m_scan = enable;
            end else if (m_tick == DWELL - 1) begin
                m_line = 7 - m_ch;
                m_a = Nin[m_line];
                m_bits[m_line] = Nin[m_line];
                for (int j = 0; j < 8; j++)
                    if (j != m_line && Nin[j] == 1'b0) m_cont = 1'b1;
                m_tick = 0;
                if (!hold) begin
                    if (m_ch == 7) begin
                        m_data = m_bits; m_fv = 1'b1; m_bits = 8'hFF; m_ch = 0;
                    end else begin
                        m_ch = m_ch + 1;
                    end
                end
            end else begin
                m_tick = m_tick + 1;
            end
            m_err = (m_err && !clr_err) || m_cont;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("input_sel", 32'(input_sel), 32'(m_ch));
            check("A_out", 32'(A_out), 32'(m_a));
            check("data_out", 32'(data_out), 32'(m_data));
            check("frame_valid", 32'(frame_valid), 32'(m_fv));
            check("err", 32'(err), 32'(m_err));
        end
    end

    // Transmitter side of the bus: only the addressed line carries data, unless overridden.
    task automatic drive_bus();
        if (ovr) begin
            Nin = ovr_val;
        end else begin
            Nin = 8'hFF;
            Nin[7 - input_sel] = bus_byte[7 - input_sel];
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        drive_bus();
    endtask

    task automatic wait_fv(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            n++;
            if (frame_valid === 1'b1) return;
        end
        check("fv_timeout", 32'(0), 32'(1));
    endtask

    task automatic restart();
        enable = 1'b0;
        cyc();
        enable = 1'b1;
        cyc();
    endtask

    int n;

    initial begin
        reset = 1'b1; enable = 1'b0; hold = 1'b0; clr_err = 1'b0; Nin = 8'hFF;
        repeat (2) @(posedge clk);
        checking = 1'b1;
        #1 reset = 1'b0;

        // Nominal frames: B2 twice, 32 cycles each
        bus_byte = 8'hB2;
        restart();
        wait_fv(n);
        check("nominal_latency", n, 32);
        check("nominal_data", data_out, 8'hB2);
        check("nominal_err", err, 0);
        wait_fv(n);
        check("second_latency", n, 32);
        check("second_data", data_out, 8'hB2);

        // Asynchronous reset mid-frame at channel 6
        for (int i = 1; i <= 24; i++) cyc();
        check("pre_reset_sel", input_sel, 6);
        #2 reset = 1'b1;
        #1;
        check("rst_sel", input_sel, 0);
        check("rst_data", data_out, 8'hFF);
        check("rst_a", A_out, 1);
        check("rst_err", err, 0);
        check("rst_fv", frame_valid, 0);
        #2 reset = 1'b0;
        cyc();
        wait_fv(n);
        check("post_reset_latency", n, 32);
        check("post_reset_data", data_out, 8'hB2);

        // Hold on channel 3 for three sample periods, toggling its bit between samples
        for (int i = 1; i <= 44; i++) begin
            cyc();
            if (i == 12) begin check("hold_sel_start", input_sel, 3); hold = 1'b1; end
            if (i == 16) begin check("hold_a0", A_out, 1); bus_byte[4] = ~bus_byte[4]; drive_bus(); end
            if (i == 20) begin check("hold_a1", A_out, 0); bus_byte[4] = ~bus_byte[4]; drive_bus(); end
            if (i == 24) begin
                check("hold_a2", A_out, 1); check("hold_sel", input_sel, 3);
                bus_byte[4] = ~bus_byte[4]; drive_bus(); hold = 1'b0;
            end
            if (i == 28) check("hold_a3", A_out, 0);
            if (i < 44) check("hold_no_fv", frame_valid, 0);
        end
        check("hold_fv_at_44", frame_valid, 1);
        check("hold_data", data_out, 8'hA2);

        // Enable drop at channel 5, then a fresh frame with different bits
        bus_byte = 8'h5C;
        for (int i = 1; i <= 20; i++) cyc();
        check("drop_sel_before", input_sel, 5);
        enable = 1'b0;
        cyc();
        check("drop_sel", input_sel, 0);
        check("drop_data", data_out, 8'hA2);
        check("drop_fv", frame_valid, 0);
        bus_byte = 8'hA3;
        enable = 1'b1;
        cyc();
        wait_fv(n);
        check("reenable_latency", n, 32);
        check("reenable_data", data_out, 8'hA3);

        // Contention on s=0, clear with clean lines, then clear colliding with a detection
        ovr = 1'b1; ovr_val = 8'hFE;
        restart();
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (i == 3) check("cont_err_before", err, 0);
            if (i == 4) begin check("cont_err_set", err, 1); ovr = 1'b0; drive_bus(); end
            if (i == 5) check("cont_err_sticky", err, 1);
            if (i == 6) clr_err = 1'b1;
            if (i == 7) begin clr_err = 1'b0; check("cont_err_cleared", err, 0); end
            if (i == 11) begin clr_err = 1'b1; ovr = 1'b1; drive_bus(); end
            if (i == 12) begin
                check("cont_set_wins", err, 1);
                clr_err = 1'b0; ovr = 1'b0; drive_bus();
            end
        end

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            enable  = ($urandom_range(0, 49) != 0);
            hold    = ($urandom_range(0, 9) == 0);
            clr_err = ($urandom_range(0, 19) == 0);
            ovr     = ($urandom_range(0, 11) == 0);
            ovr_val = 8'($urandom);
            if (input_sel == 3'd0 && $urandom_range(0, 3) == 0) bus_byte = 8'($urandom);
            drive_bus();
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
